// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word memory for the CPU memory stage.
// One request is in flight at a time; errors complete with the same latency.
module data_mem_responder #(
  parameter int DEPTH   = 128,
  parameter int LATENCY = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic        err_o,
  output logic [31:0] data_o,
  output logic        stall_o
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q;
  logic [3:0] cnt_q;
  logic rd_q, wr_q, ack_q, err_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [31:0] mem [DEPTH];
  logic accept, enter_resp, op_rd, op_wr, op_err;
  logic [31:0] op_addr, op_data;
  logic [AW-1:0] op_idx;
  assign accept = state_q == IDLE && req_i;
  assign enter_resp = (accept && LATENCY == 1) || (state_q == BUSY && cnt_q == 4'd1);
  // With LATENCY=1 the request completes on its accepting edge, so use live inputs
  assign op_rd = state_q == IDLE ? MemRead_i : rd_q;
  assign op_wr = state_q == IDLE ? MemWrite_i : wr_q;
  assign op_addr = state_q == IDLE ? addr_i : addr_q;
  assign op_data = state_q == IDLE ? data_i : wdata_q;
  assign op_idx = op_addr[AW+1:2];
  assign op_err = op_rd == op_wr || op_addr[1:0] != 2'b00 || op_addr[31:2] >= DEPTH_W;
  assign ready_o = state_q == IDLE;
  assign stall_o = state_q == BUSY || accept;
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign data_o = data_q;
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      data_q <= 32'd0;
    end else begin
      ack_q <= enter_resp;
      err_q <= enter_resp && op_err;
      if (enter_resp && op_rd && !op_err) data_q <= mem[op_idx];
      case (state_q)
        IDLE: if (req_i) begin
          rd_q <= MemRead_i;
          wr_q <= MemWrite_i;
          addr_q <= addr_i;
          wdata_q <= data_i;
          cnt_q <= CNT_INIT;
          state_q <= LATENCY == 1 ? RESP : BUSY;
        end
        BUSY: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Stores commit only on completion; reset blocks the commit of an aborted store
  always_ff @(posedge clk_i)
    if (rst_i && enter_resp && op_wr && !op_err) mem[op_idx] <= op_data;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks against a word-array model.
module tb_data_mem_responder;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  logic req, rd, wr, ready, ack, err, stall;
  logic [31:0] addr, wdata, rdata;
  logic req1, rd1, wr1, ready1, ack1, err1, stall1;
  logic [31:0] addr1, wdata1, rdata1;
  int checks = 0;
  int failures = 0;
  logic [31:0] model_mem [128];
  logic [31:0] exp_data = 0;

  data_mem_responder #(.DEPTH(128), .LATENCY(3)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .MemRead_i(rd), .MemWrite_i(wr),
    .addr_i(addr), .data_i(wdata), .ready_o(ready), .ack_o(ack), .err_o(err),
    .data_o(rdata), .stall_o(stall)
  );

  data_mem_responder #(.DEPTH(128), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .MemRead_i(rd1), .MemWrite_i(wr1),
    .addr_i(addr1), .data_i(wdata1), .ready_o(ready1), .ack_o(ack1), .err_o(err1),
    .data_o(rdata1), .stall_o(stall1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_err(input logic r, input logic w, input logic [31:0] a);
    return r == w || a[1:0] != 2'b00 || a[31:2] >= 30'd128;
  endfunction

  task automatic xact(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    logic e;
    int n;
    e = is_err(r, w, a);
    @(negedge clk);
    chk("ready_idle", ready, 1);
    req = 1; rd = r; wr = w; addr = a; wdata = d;
    #1 chk("stall_req", stall, 1);
    @(posedge clk);
    @(negedge clk);
    req = 0; rd = 1'($urandom); wr = 1'($urandom); addr = $urandom; wdata = $urandom;
    n = 1;
    while (!ack && n < 20) begin
      chk("ready_busy", ready, 0);
      chk("stall_busy", stall, 1);
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 3);
    chk("ack", ack, 1);
    chk("err", err, 32'(e));
    chk("ready_resp", ready, 0);
    chk("stall_resp", stall, 0);
    if (!e && w) model_mem[a[8:2]] = d;
    if (!e && r) exp_data = model_mem[a[8:2]];
    chk("data", rdata, exp_data);
    @(negedge clk);
    chk("ack_drop", ack, 0);
    chk("ready_back", ready, 1);
  endtask

  task automatic idle_hold(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      chk("hold_ack", ack, 0);
      chk("hold_data", rdata, exp_data);
      chk("hold_ready", ready, 1);
    end
  endtask

  initial begin
    logic [31:0] a, d;
    int k, m;
    req = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
    req1 = 0; rd1 = 0; wr1 = 0; addr1 = 0; wdata1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1;
    chk("rst_ready", ready, 1);
    chk("rst_ack", ack, 0);
    chk("rst_err", err, 0);
    chk("rst_data", rdata, 0);
    chk("rst_stall", stall, 0);
    for (int i = 0; i < 128; i++) xact(0, 1, 32'(i) << 2, $urandom);
    xact(0, 1, 32'h10, 32'hDEADBEEF);
    xact(1, 0, 32'h10, 0);
    chk("load_10", rdata, 32'hDEADBEEF);
    idle_hold(5);
    xact(1, 0, 32'h12, 0);
    xact(0, 1, 32'h200, 32'hCAFEF00D);
    xact(1, 0, 32'h10, 0);
    chk("load_10_again", rdata, 32'hDEADBEEF);
    xact(0, 1, 32'h20, 32'hA5A5A5A5);
    @(negedge clk);
    req = 1; rd = 0; wr = 1; addr = 32'h20; wdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    req = 0; rst = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1;
    exp_data = 0;
    chk("abort_data", rdata, 0);
    chk("abort_ready", ready, 1);
    repeat (4) begin
      chk("abort_ack", ack, 0);
      @(negedge clk);
    end
    xact(1, 0, 32'h20, 0);
    chk("abort_load", rdata, 32'hA5A5A5A5);
    for (int i = 0; i < 60; i++) begin
      k = $urandom_range(0, 9);
      m = $urandom_range(0, 9);
      a = m == 0 ? (32'($urandom_range(0, 127)) << 2) | 32'($urandom_range(1, 3)) :
          m == 1 ? 32'($urandom_range(128, 4000)) << 2 : 32'($urandom_range(0, 15)) << 2;
      d = $urandom;
      xact(k == 0 || (k >= 2 && k <= 5), k == 0 || k >= 6, a, d);
      idle_hold($urandom_range(0, 3));
    end
    @(negedge clk);
    req1 = 1; rd1 = 0; wr1 = 1; addr1 = 32'h4; wdata1 = 32'h0BADC0DE;
    #1 chk("l1_stall_req", stall1, 1);
    @(posedge clk);
    @(negedge clk);
    chk("l1_st_ack", ack1, 1);
    chk("l1_st_err", err1, 0);
    chk("l1_resp_ready", ready1, 0);
    chk("l1_resp_stall", stall1, 0);
    rd1 = 1; wr1 = 0; wdata1 = 0;
    @(posedge clk);
    @(negedge clk);
    chk("l1_gap_ack", ack1, 0);
    chk("l1_gap_ready", ready1, 1);
    chk("l1_gap_stall", stall1, 1);
    @(posedge clk);
    @(negedge clk);
    chk("l1_ld_ack", ack1, 1);
    chk("l1_ld_err", err1, 0);
    chk("l1_ld_data", rdata1, 32'h0BADC0DE);
    req1 = 0;
    @(negedge clk);
    chk("l1_ack_drop", ack1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 128: number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 3, legal range 1..15: cycles from request acceptance to ack.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous active-low reset.
REQ-006 SHALL have port req_i  input  1  request valid from the CPU memory stage.
REQ-007 SHALL have port MemRead_i  input  1  the request is a load.
REQ-008 SHALL have port MemWrite_i  input  1  the request is a store.
REQ-009 SHALL have port addr_i  input  32  byte address; word index is addr_i[31:2].
REQ-010 SHALL have port data_i  input  32  store data.
REQ-011 SHALL have port ready_o  output  1  responder can accept a request this cycle.
REQ-012 SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err_o  output  1  completion was an error; valid only while ack_o=1.
REQ-014 SHALL have port data_o  output  32  load data; valid while ack_o=1 and held until the next ack.
REQ-015 SHALL have port stall_o  output  1  high from acceptance through the cycle before ack; drives CPU pc_write and IF/ID write gating.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY and RESP; ready_o=1 only in IDLE.
REQ-017 SHALL accept a request at a rising edge where state=IDLE, req_i=1 and rst_i=1, and latch op, addr_i and data_i at that edge.
REQ-018 SHALL, on accept, load a 4-bit counter with LATENCY-1 and go to RESP if LATENCY=1, otherwise to BUSY.
REQ-019 SHALL, in BUSY, decrement the counter each cycle and go to RESP on the edge where the counter equals 1.
REQ-020 SHALL assert ack_o only in RESP, so ack_o is high during the cycle LATENCY edges after the accepting edge, then return to IDLE.
REQ-021 SHALL commit a store to memory on the edge that enters RESP, not at acceptance.
REQ-022 SHALL register the load result into data_o on the edge that enters RESP.
REQ-023 SHALL ignore req_i while not in IDLE; there is no queueing, and back-to-back throughput is one request per LATENCY+1 cycles.
REQ-024 SHALL treat the following as errors: both MemRead_i and MemWrite_i high, neither high, addr_i[1:0]!=0, or addr_i[31:2]>=DEPTH.
REQ-025 SHALL run an error request through the same latency with err_o=1 in RESP, leave memory unchanged, and leave data_o unchanged.
REQ-026 SHALL drive stall_o as (state=BUSY) or (state=IDLE and req_i=1), combinationally, so the requesting instruction is held.
REQ-027 SHALL, when a store and a following load to the same word are issued sequentially, return the stored value to the load.

Reset
REQ-028 SHALL, while rst_i=0 at a rising edge, force state=IDLE, counter=0, ack_o=0, err_o=0 and data_o=0, so ready_o=1 after reset.
REQ-029 SHALL abort an in-flight request on reset: a pending store is never committed and no ack is issued.
REQ-030 SHALL NOT clear memory contents on reset.

Verification
REQ-031 Reset, then store at addr 0x10 with data 0xDEADBEEF accepted at edge T -> ack_o=1, err_o=0 in cycle T+3, ready_o=0 during T+1..T+3, ready_o=1 in T+4.
REQ-032 Then load at addr 0x10 -> ack_o after 3 cycles with data_o=0xDEADBEEF; data_o is held through an idle period of 5 cycles.
REQ-033 Misaligned load at addr 0x12, and a store at addr 0x200 (word 128>=DEPTH) -> each gives ack_o=1, err_o=1; a following load at 0x10 still returns 0xDEADBEEF.
REQ-034 Store at 0x20 with data 0x12345678, rst_i=0 pulsed at T+1 -> no ack; a following load at 0x20 does not return 0x12345678 (it returns the previous contents).
REQ-035 With LATENCY=1, issue a store to 0x4 and then a load from 0x4, with req_i held high the whole time -> acks 2 cycles apart and the load returns the stored data; the request presented during RESP is not accepted until IDLE.
